// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter
// Two-port round-robin arbiter and burst sequencer in front of a single-port
// control ROM. A granted requester gets one ROM read issued per cycle for
// the length of its burst. The returned words are steered back to it with
// per-port valid and done strobes.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   req_a / req_b       burst request, level, only looked at while idle
//   addr_a / addr_b     burst start address, sampled with the request
//   len_a / len_b       burst length, 1..15 words, 0 means 16 words
//   gnt_a / gnt_b       one-cycle pulse in the first issue cycle of a burst
//   rvalid_a / rvalid_b rdata holds a word for this port
//   done_a / done_b     high together with the last rvalid of a burst
//   rdata               ROM data passed straight through, shared by both ports
//   rom_en / rom_addr   ROM read port
//   rom_data            ROM read data, valid LAT cycles after rom_en
module rom_burst_arbiter #(
    parameter int AW  = 8,
    parameter int DW  = 16,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic [AW-1:0] addr_a,
    input  logic [3:0]    len_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_b,
    input  logic [3:0]    len_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic          done_a,
    output logic          done_b,
    output logic [DW-1:0] rdata,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] cur_addr;
    logic [4:0]    remaining;
    logic          owner_b;
    logic          last_b;
    logic          grant_a;
    logic          grant_b;
    logic          issue;
    logic          issue_last;
    logic          out_done;

    logic [LAT-1:0] pipe_valid;
    logic [LAT-1:0] pipe_owner_b;
    logic [LAT-1:0] pipe_last;

    // Round-robin choice while idle. A lone request always wins. When both
    // ports ask at once, the port that was not served last wins. last_b
    // resets to 1, so A wins the very first contention.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (req_a && req_b) begin
                grant_a = last_b;
                grant_b = ~last_b;
            end else if (req_a) begin
                grant_a = 1'b1;
            end else if (req_b) begin
                grant_b = 1'b1;
            end
        end
    end

    assign issue      = (state == BURST);
    assign issue_last = issue && (remaining == 5'd1);
    assign rom_en     = issue;
    assign rom_addr   = cur_addr;

    // Main sequencer. The grant pulse is registered, so it lands in the first
    // BURST cycle. cur_addr is not advanced on the final issue edge. That way
    // rom_addr keeps showing the last address actually read while the
    // sequencer drains or sits idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= 5'd0;
            owner_b   <= 1'b0;
            last_b    <= 1'b1;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
        end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        owner_b  <= grant_b;
                        last_b   <= grant_b;
                        gnt_a    <= grant_a;
                        gnt_b    <= grant_b;
                        cur_addr <= grant_b ? addr_b : addr_a;
                        if (grant_b) begin
                            remaining <= (len_b == 4'd0) ? 5'd16 : {1'b0, len_b};
                        end else begin
                            remaining <= (len_a == 4'd0) ? 5'd16 : {1'b0, len_a};
                        end
                        state <= BURST;
                    end
                end
                BURST: begin
                    remaining <= remaining - 5'd1;
                    if (remaining == 5'd1) begin
                        state <= DRAIN;
                    end else begin
                        cur_addr <= cur_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    if (out_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Return pipeline. This is one stage per cycle of ROM latency. It carries
    // who the word belongs to and whether it closes the burst, so the strobes
    // line up exactly with rom_data at the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid   <= '0;
            pipe_owner_b <= '0;
            pipe_last    <= '0;
        end else begin
            pipe_valid[0]   <= issue;
            pipe_owner_b[0] <= owner_b;
            pipe_last[0]    <= issue_last;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid[i]   <= pipe_valid[i-1];
                pipe_owner_b[i] <= pipe_owner_b[i-1];
                pipe_last[i]    <= pipe_last[i-1];
            end
        end
    end

    assign rvalid_a = pipe_valid[LAT-1] & ~pipe_owner_b[LAT-1];
    assign rvalid_b = pipe_valid[LAT-1] &  pipe_owner_b[LAT-1];
    assign done_a   = rvalid_a & pipe_last[LAT-1];
    assign done_b   = rvalid_b & pipe_last[LAT-1];
    assign out_done = pipe_valid[LAT-1] & pipe_last[LAT-1];
    assign rdata    = rom_data;

endmodule
